tff_toggle_arbiter: RTL and testbench
=====================================

# tff_toggle_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit T flip-flop bank between NUM_REQ requesters. Each granted requester supplies a toggle mask and a toggle count. The block drives the mask into the bank's T inputs for exactly that many clock edges, then releases the bank. It sits between independent control agents and the shared toggle register, which it owns and exposes as `q`.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 4: T flip-flop bank width.
- `CNT_W`, default 4: toggle-count width; maximum run is 2^CNT_W-1 toggles.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `req`, input, NUM_REQ: per-requester request, level-sensitive.
- `mask`, input, NUM_REQ*WIDTH: requester i mask in bits [i*WIDTH +: WIDTH].
- `len`, input, NUM_REQ*CNT_W: requester i toggle count in bits [i*CNT_W +: CNT_W].
- `gnt`, output, NUM_REQ: one-hot grant.
- `busy`, output, 1: asserted while state is not IDLE.
- `done`, output, 1: one-cycle pulse at the end of a grant.
- `t_in`, output, WIDTH: T inputs currently applied to the bank.
- `q`, output, WIDTH: bank state.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **IDLE:**
  - If any `req` bit is set, select the winner by round-robin search starting at `rr_ptr+1` and wrapping modulo NUM_REQ.
  - On that edge, latch the winner's `mask` into `mask_q` and its `len` into `cnt`, and set `gnt` one-hot.
  - If the latched `len` is not 0, go to RUN. If it is 0, go to DONE.
- **RUN:**
  - `t_in` = `mask_q`, combinationally from state.
  - On each edge, `q` <= `q ^ mask_q` and `cnt` <= `cnt-1`.
  - On the edge where `cnt`==1, go to DONE. Exactly `len` toggles occur.
- **DONE:**
  - `done`=1 and `t_in`=0; `gnt` is still held.
  - On the next edge: go to IDLE, set `rr_ptr` <= winner index, clear `gnt`.
- `t_in` is 0 in IDLE and DONE.
- `q` changes only in RUN.
- `mask`/`len` changes from a requester after its grant edge are ignored until its next grant.
- A `req` dropped during RUN does not abort the run.
- A requester still holding `req` in IDLE re-competes. Round-robin priority places it last.
- Width rule: `cnt` is CNT_W bits unsigned; it never underflows because RUN is only entered with `cnt` ≥ 1.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `gnt`=0, `busy`=0, `done`=0, `t_in`=0, `q`=0, `cnt`=0, `mask_q`=0, `rr_ptr`=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-RUN: `q` clears immediately and the run is discarded; no `done` pulse.
- Arbitration latency: a `req` seen in IDLE gives `gnt` 1 cycle later.
- Grant occupancy: `len`+1 cycles with `gnt` high (`len` RUN cycles plus 1 DONE cycle).
  - `len`=0 gives 1 cycle (DONE only).
- Back-to-back service: IDLE takes 1 cycle between grants, so the period per grant is `len`+2 cycles.
- `done` is high only in DONE, coincident with the final `gnt` cycle; requesters qualify it with their `gnt` bit.
- Simultaneous requests are resolved solely by `rr_ptr`; there is no fixed priority after reset.

## Structure
- Shared package `tff_arb_pkg` holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default parameter constants.
- Sub-module `tff_bank`:
  - ports: `clk`, `rst`, `t_in[WIDTH]`, `q[WIDTH]`;
  - behaviour: `q` <= `q ^ t_in` on the edge, asynchronous active-low clear.
- The arbiter top holds the FSM, round-robin picker, `cnt`, `mask_q` and `rr_ptr`.

## Test plan
- **Reset values:** hold `rst`=0 for 2 cycles → all outputs 0, `busy`=0.
- **Single request:** `req`=0001, mask0=1010, len0=3 → `gnt`=0001 for 4 cycles; `q` goes 0000→1010→0000→1010; `done` pulses in cycle 4 of the grant.
- **All requesters at once:** `req`=1111, len=1 each, masks 0001/0010/0100/1000 → grants in order 0,1,2,3, 3 cycles apart; final `q`=1111.
- **Zero-length request:** len2=0, only `req`[2] set → `gnt`=0100 for 1 cycle with `done`=1; `q` unchanged; `t_in` stays 0.
- **Fairness under continuous requests:** `req`[1] and `req`[3] held continuously → grants alternate 1,3,1,3; neither is granted twice in a row.
- **Reset mid-run:** len0=10, assert `rst` low on the 4th RUN cycle → `q`, `gnt`, `t_in` go to 0 asynchronously, no `done`; after release, requester 0 is re-granted if `req`[0] is still high.

Source files
------------

// File: rtl/tff_arb_pkg.sv
// Shared definitions for the toggle-bank arbiter: FSM state encoding and
// default parameter values.
package tff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;
    localparam int DEF_CNT_W   = 4;

endpackage

// File: rtl/tff_bank.sv
// Bank of T flip-flops: each bit flips on a rising edge when its T input is set.
module tff_bank
    import tff_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q <= q ^ t_in;
        end
    end

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter that lends a shared T flip-flop bank to one requester at a
// time and applies its toggle mask for the requested number of clock edges.
module tff_toggle_arbiter
    import tff_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] mask,
    input  logic [NUM_REQ*CNT_W-1:0] len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         t_in,
    output logic [WIDTH-1:0]         q
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mask_q;
    logic [IDX_W-1:0] win_q;
    logic [IDX_W-1:0] rr_ptr;

    logic             any_req;
    logic [IDX_W-1:0] pick;
    logic [WIDTH-1:0] pick_mask;
    logic [CNT_W-1:0] pick_len;
    int               idx;

    // Search starts just after the last winner, so it ends up lowest priority.
    always_comb begin
        any_req   = 1'b0;
        pick      = '0;
        pick_mask = '0;
        pick_len  = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!any_req && req[idx]) begin
                any_req   = 1'b1;
                pick      = IDX_W'(idx);
                pick_mask = mask[idx*WIDTH +: WIDTH];
                pick_len  = len[idx*CNT_W +: CNT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = (pick_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The winner's request is captured at grant time; later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            mask_q <= '0;
            win_q  <= '0;
            rr_ptr <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cnt    <= pick_len;
                        mask_q <= pick_mask;
                        win_q  <= pick;
                    end
                end
                RUN:     cnt    <= cnt - 1'b1;
                DONE:    rr_ptr <= win_q;
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign gnt  = busy ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_q) : '0;
    assign t_in = (state == RUN) ? mask_q : '0;

    tff_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk (clk),
        .rst (rst),
        .t_in(t_in),
        .q   (q)
    );

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Self-checking bench for tff_toggle_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle against a transaction-level reference model.
module tb_tff_toggle_arbiter;

    localparam int NR = 4;
    localparam int W  = 4;
    localparam int CW = 4;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*W-1:0] mask;
    logic [NR*CW-1:0] len;
    logic [NR-1:0]   gnt;
    logic            busy;
    logic            done;
    logic [W-1:0]    t_in;
    logic [W-1:0]    q;

    int testsRun;
    int failCount;

    // Reference model: who owns the bank, how many toggles remain, and whether
    // the closing cycle of the grant is in progress.
    int        mOwner;
    int        mLeft;
    int        mLast;
    bit        mClosing;
    logic [W-1:0] mMask;
    logic [W-1:0] mQ;

    tff_toggle_arbiter #(
        .NUM_REQ(NR),
        .WIDTH  (W),
        .CNT_W  (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .mask(mask),
        .len (len),
        .gnt (gnt),
        .busy(busy),
        .done(done),
        .t_in(t_in),
        .q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mOwner   = -1;
        mLeft    = 0;
        mLast    = NR - 1;
        mClosing = 1'b0;
        mMask    = '0;
        mQ       = '0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic modelEdge();
        int  idx;
        bit  found;
        if (!rst) return;
        if (mClosing) begin
            mLast    = mOwner;
            mOwner   = -1;
            mClosing = 1'b0;
        end else if (mOwner >= 0) begin
            mQ    = mQ ^ mMask;
            mLeft = mLeft - 1;
            if (mLeft == 0) mClosing = 1'b1;
        end else begin
            found = 1'b0;
            for (int k = 1; k <= NR; k++) begin
                idx = (mLast + k) % NR;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    mOwner   = idx;
                    mMask    = mask[idx*W +: W];
                    mLeft    = int'(len[idx*CW +: CW]);
                    mClosing = (mLeft == 0);
                end
            end
        end
    endtask

    task automatic checkAll(input string tag);
        logic [NR-1:0] eGnt;
        logic [W-1:0]  eT;
        eGnt = (mOwner >= 0) ? (NR'(1) << mOwner) : '0;
        eT   = (mOwner >= 0 && !mClosing) ? mMask : '0;
        checkOutput({tag, "/gnt"},  32'(gnt),  32'(eGnt));
        checkOutput({tag, "/busy"}, 32'(busy), 32'(mOwner >= 0));
        checkOutput({tag, "/done"}, 32'(done), 32'(mClosing));
        checkOutput({tag, "/t_in"}, 32'(t_in), 32'(eT));
        checkOutput({tag, "/q"},    32'(q),    32'(mQ));
    endtask

    task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR*W-1:0] m, input logic [NR*CW-1:0] l);
        req  = r;
        mask = m;
        len  = l;
    endtask

    task automatic runCycles(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            modelEdge();
            @(negedge clk);
            checkAll(tag);
        end
    endtask

    // Asynchronous reset applied between edges; outputs must clear immediately.
    task automatic applyReset(input string tag);
        rst = 1'b0;
        #1;
        modelReset();
        checkAll(tag);
        @(posedge clk);
        @(negedge clk);
        checkAll(tag);
        rst = 1'b1;
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        rst = 1'b0;
        applyStimulus('0, '0, '0);
        modelReset();
        repeat (2) @(negedge clk);
        checkAll("reset");
        rst = 1'b1;

        // Single request, three toggles of 1010
        applyStimulus(4'b0001, 16'h000A, 16'h0003);
        runCycles(1, "single");
        checkOutput("single_gnt", 32'(gnt), 32'h1);
        applyStimulus(4'b0000, 16'h000A, 16'h0003);
        runCycles(2, "single");
        checkOutput("single_q_mid", 32'(q), 32'h0);
        runCycles(1, "single");
        checkOutput("single_done", 32'(done), 32'h1);
        checkOutput("single_q_end", 32'(q), 32'hA);
        runCycles(2, "single");

        // All four at once, one toggle each
        applyReset("rst_all");
        applyStimulus(4'b1111, 16'h8421, 16'h1111);
        runCycles(10, "all");
        applyStimulus(4'b0000, 16'h8421, 16'h1111);
        runCycles(3, "all");
        checkOutput("all_final_q", 32'(q), 32'hF);

        // Zero-length request
        applyReset("rst_zero");
        applyStimulus(4'b0100, 16'hFFFF, 16'h0000);
        runCycles(1, "zero");
        checkOutput("zero_gnt", 32'(gnt), 32'h4);
        checkOutput("zero_done", 32'(done), 32'h1);
        checkOutput("zero_tin", 32'(t_in), 32'h0);
        applyStimulus(4'b0000, 16'hFFFF, 16'h0000);
        runCycles(2, "zero");

        // Fairness with two continuous requesters
        applyStimulus(4'b1010, 16'h3C5A, 16'h2130);
        runCycles(30, "fair");
        applyStimulus(4'b0000, 16'h3C5A, 16'h2130);
        runCycles(6, "fair");

        // Reset in the middle of a long run
        applyReset("rst_pre");
        applyStimulus(4'b0001, 16'h0007, 16'h000A);
        runCycles(4, "midrun");
        applyReset("midrun_rst");
        runCycles(1, "after_rst");
        checkOutput("regrant", 32'(gnt), 32'h1);
        applyStimulus(4'b0000, 16'h0007, 16'h000A);
        runCycles(12, "after_rst");

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [NR*CW-1:0] rl;
            for (int j = 0; j < NR; j++) rl[j*CW +: CW] = CW'($urandom_range(0, 5));
            applyStimulus(NR'($urandom), (NR*W)'($urandom), rl);
            if ($urandom_range(0, 99) == 0) applyReset("rand_rst");
            else runCycles(1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
